// File: rtl/regfile_sb_pkg.sv
// Shared constants for the Y86-64 register file with scoreboard.
// WORD is the data width macro shared with the existing core defines.
`ifndef WORD
`define WORD 64
`endif

package regfile_sb_pkg;

    localparam int WORD_W = `WORD;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 2;

    localparam logic [REG_AW-1:0] RNONE = {REG_AW{1'b1}};

    typedef enum logic [REG_AW-1:0] {
        RAX = 4'd0,  RCX = 4'd1,  RDX = 4'd2,  RBX = 4'd3,
        RSP = 4'd4,  RBP = 4'd5,  RSI = 4'd6,  RDI = 4'd7,
        R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11,
        R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, RNO = 4'd15
    } reg_id_e;

endpackage

// File: rtl/regfile_sb_chk.sv
// Simulation checker: flags a retire against a register with no outstanding write.
module regfile_sb_chk #(
    parameter int N = 15
) (
    input logic         clk,
    input logic         rst,
    input logic [N-1:0] unf
);
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) unf == '0);

endmodule

// File: rtl/regfile_sb_cnt.sv
// One scoreboard counter: saturating up/down by 0/1/2 with overflow lookahead.
module regfile_sb_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc1,
    input  logic            inc2,
    input  logic            inc_en,
    input  logic            dec1,
    input  logic            dec2,
    output logic [CNTW-1:0] cnt,
    output logic            ovf,
    output logic            unf
);
    localparam int XW = CNTW + 2;
    localparam logic [XW-1:0] CMAX = XW'((1 << CNTW) - 1);

    logic [CNTW-1:0] cnt_r;
    logic [XW-1:0]   inc_x_s;
    logic [XW-1:0]   dec_x_s;
    logic [XW-1:0]   after_dec_s;
    logic [XW-1:0]   next_x_s;

    // Net delta: retire first (clamped at zero), then add the issue if accepted
    always_comb begin
        inc_x_s = inc2 ? XW'(2) : (inc1 ? XW'(1) : XW'(0));
        dec_x_s = dec2 ? XW'(2) : (dec1 ? XW'(1) : XW'(0));
        unf     = (dec_x_s > XW'(cnt_r));
        if (unf) begin
            after_dec_s = '0;
        end else begin
            after_dec_s = XW'(cnt_r) - dec_x_s;
        end
        ovf = ((after_dec_s + inc_x_s) > CMAX);
        if (inc_en) begin
            next_x_s = after_dec_s + inc_x_s;
        end else begin
            next_x_s = after_dec_s;
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= next_x_s[CNTW-1:0];
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Y86-64 register file, 2 read / 2 write ports, with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle writeback forwarding on reads and busy.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AW    = REG_AW,
    parameter int CNTW  = CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AW-1:0]               srcA,
    input  logic [AW-1:0]               srcB,
    output logic [WIDTH-1:0]            valA,
    output logic [WIDTH-1:0]            valB,
    output logic                        busyA,
    output logic                        busyB,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_dstE,
    input  logic [AW-1:0]               iss_dstM,
    output logic                        iss_ready,
    input  logic [AW-1:0]               dstE,
    input  logic [AW-1:0]               dstM,
    input  logic [WIDTH-1:0]            valE,
    input  logic [WIDTH-1:0]            valM,
    output logic [(2**AW)*WIDTH-1:0]    regs_flat
);
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] RN = {AW{1'b1}};

    logic [WIDTH-1:0] rd_s  [NREG];
    logic [CNTW-1:0]  cnt_s [NREG];
    logic [NREG-2:0]  ovf_s;
    logic [NREG-2:0]  unf_s;
    logic [1:0]       ret_a_s;
    logic [1:0]       ret_b_s;

    // RNONE has no storage: its read slot, counter slot and debug slice are zero
    assign rd_s[NREG-1]  = '0;
    assign cnt_s[NREG-1] = '0;
    assign regs_flat[NREG*WIDTH-1 -: WIDTH] = '0;

    for (genvar g = 0; g < NREG - 1; g++) begin : g_ent
        localparam logic [AW-1:0] IDX = AW'(g);
        logic [WIDTH-1:0] reg_r;
        logic             ie_s;
        logic             im_s;
        logic             we_s;
        logic             wm_s;

        assign ie_s = iss_valid && (iss_dstE == IDX);
        assign im_s = iss_valid && (iss_dstM == IDX);
        assign we_s = (dstE == IDX);
        assign wm_s = (dstM == IDX);

        // Storage; M port wins a same-index collision
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                reg_r <= '0;
            end else if (wm_s) begin
                reg_r <= valM;
            end else if (we_s) begin
                reg_r <= valE;
            end else begin
                reg_r <= reg_r;
            end
        end

        regfile_sb_cnt #(.CNTW(CNTW)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc1   (ie_s ^ im_s),
            .inc2   (ie_s & im_s),
            .inc_en (iss_ready),
            .dec1   (we_s ^ wm_s),
            .dec2   (we_s & wm_s),
            .cnt    (cnt_s[g]),
            .ovf    (ovf_s[g]),
            .unf    (unf_s[g])
        );

        assign rd_s[g] = reg_r;
        assign regs_flat[g*WIDTH +: WIDTH] = reg_r;
    end

    assign iss_ready = ~|ovf_s;

    // Read muxes; the bypass build forwards incoming writeback data, M over E
    always_comb begin
        valA = rd_s[srcA];
        valB = rd_s[srcB];
`ifdef REGFILE_BYPASS_EN
        if ((srcA != RN) && (srcA == dstM)) begin
            valA = valM;
        end else if ((srcA != RN) && (srcA == dstE)) begin
            valA = valE;
        end else begin
            valA = rd_s[srcA];
        end
        if ((srcB != RN) && (srcB == dstM)) begin
            valB = valM;
        end else if ((srcB != RN) && (srcB == dstE)) begin
            valB = valE;
        end else begin
            valB = rd_s[srcB];
        end
`endif
    end

    // Busy: outstanding writes beyond those retiring this cycle (bypass only)
    always_comb begin
        ret_a_s = 2'd0;
        ret_b_s = 2'd0;
`ifdef REGFILE_BYPASS_EN
        ret_a_s = {1'b0, (srcA == dstE)} + {1'b0, (srcA == dstM)};
        ret_b_s = {1'b0, (srcB == dstE)} + {1'b0, (srcB == dstM)};
`endif
        busyA = (srcA != RN) && ((CNTW+2)'(cnt_s[srcA]) > (CNTW+2)'(ret_a_s));
        busyB = (srcB != RN) && ((CNTW+2)'(cnt_s[srcB]) > (CNTW+2)'(ret_b_s));
    end

    regfile_sb_chk #(.N(NREG - 1)) u_chk (
        .clk (clk),
        .rst (rst),
        .unf (unf_s)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table, directed corners, random vs model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    srcA, srcB, iss_dstE, iss_dstM, dstE, dstM;
    logic [63:0]   valA, valB, valE, valM;
    logic          busyA, busyB, iss_valid, iss_ready;
    logic [1023:0] regs_flat;

    regfile_sb dut (
        .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busyA(busyA), .busyB(busyB), .iss_valid(iss_valid), .iss_dstE(iss_dstE),
        .iss_dstM(iss_dstM), .iss_ready(iss_ready), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] mem [16];
    int          cnt [16];

    typedef struct {
        logic [3:0]  a, b;
        logic        iv;
        logic [3:0]  ie, im, de, dm;
        logic [63:0] ve, vm;
        logic [63:0] xa, xb;
        logic        ba, bb, rdy;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flat(input string name, input logic [1023:0] exp);
        tests++;
        if (regs_flat !== exp) begin
            fails++;
            for (int i = 0; i < 16; i++) begin
                if (regs_flat[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("FAIL %s: entry %0d got %0h expected %0h", name, i,
                             regs_flat[i*64 +: 64], exp[i*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic iv,
                         input logic [3:0] ie, input logic [3:0] im, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        srcA = a; srcB = b; iss_valid = iv; iss_dstE = ie; iss_dstM = im;
        dstE = de; dstM = dm; valE = ve; valM = vm;
    endtask

    task automatic idle(input logic [3:0] a, input logic [3:0] b);
        drive(a, b, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
    endtask

    function automatic int hits(input logic [3:0] x, input logic [3:0] y, input int r);
        return int'(x == 4'(r)) + int'(y == 4'(r));
    endfunction

    // Reference read: stored value, optionally overridden by incoming writeback
    function automatic logic [63:0] m_read(input logic [3:0] s);
        if (s == 4'hF) return 64'h0;
        if (BYP && s == dstM) return valM;
        if (BYP && s == dstE) return valE;
        return mem[s];
    endfunction

    function automatic logic m_busy(input logic [3:0] s);
        int r;
        if (s == 4'hF) return 1'b0;
        r = BYP ? hits(dstE, dstM, int'(s)) : 0;
        return cnt[s] > r;
    endfunction

    function automatic logic m_ready();
        int inc, c;
        for (int r = 0; r < 15; r++) begin
            inc = iss_valid ? hits(iss_dstE, iss_dstM, r) : 0;
            c = cnt[r] - hits(dstE, dstM, r);
            if (c < 0) c = 0;
            if (inc > 0 && c + inc > 3) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [1023:0] m_flat();
        logic [1023:0] f = '0;
        for (int r = 0; r < 15; r++) f[r*64 +: 64] = mem[r];
        return f;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 16; r++) begin
            mem[r] = 64'h0;
            cnt[r] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valA"}, valA, m_read(srcA));
        chk({tag, "_valB"}, valB, m_read(srcB));
        chk({tag, "_busyA"}, 64'(busyA), 64'(m_busy(srcA)));
        chk({tag, "_busyB"}, 64'(busyB), 64'(m_busy(srcB)));
        chk({tag, "_ready"}, 64'(iss_ready), 64'(m_ready()));
        chk_flat({tag, "_flat"}, m_flat());
    endtask

    // One clock: inputs are stable from the previous negedge; model follows the edge
    task automatic cycle();
        logic rdy;
        int   c;
        rdy = m_ready();
        @(posedge clk);
        for (int r = 0; r < 15; r++) begin
            c = cnt[r] - hits(dstE, dstM, r);
            if (c < 0) c = 0;
            cnt[r] = c + ((rdy && iss_valid) ? hits(iss_dstE, iss_dstM, r) : 0);
        end
        if (dstE != 4'hF) mem[dstE] = valE;
        if (dstM != 4'hF) mem[dstM] = valM;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] de, dm;
        m_reset();
        rst = 1'b1;
        idle(4'h0, 4'h1);
        repeat (2) @(negedge clk);
        chk_flat("rst_flat", '0);
        chk("rst_valA", valA, 64'h0);
        chk("rst_busyA", 64'(busyA), 64'h0);
        chk("rst_ready", 64'(iss_ready), 64'h1);
        rst = 1'b0;
        @(negedge clk);

        //          a     b     iv    ie    im    de    dm    ve        vm        xa                xb                ba              bb              rdy
        tbl[0]  = '{4'h0, 4'h1, 1'b1, 4'h0, 4'h1, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,            64'h0,            1'b0,           1'b0,           1'b1};
        tbl[1]  = '{4'h0, 4'h1, 1'b1, 4'h4, 4'h4, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,            64'h0,            1'b1,           1'b1,           1'b1};
        tbl[2]  = '{4'h4, 4'hF, 1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 64'h1234, 64'h5678, 64'h0,            64'h0,            1'b1,           1'b0,           1'b1};
        tbl[3]  = '{4'h0, 4'h1, 1'b0, 4'hF, 4'hF, 4'h4, 4'h4, 64'hAA,   64'hBB,   64'h1234,         64'h5678,         1'b0,           1'b0,           1'b1};
        tbl[4]  = '{4'h4, 4'h2, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'hBB,           64'h0,            1'b0,           1'b0,           1'b1};
        tbl[5]  = '{4'h3, 4'h4, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,            64'hBB,           1'b1,           1'b0,           1'b1};
        tbl[6]  = '{4'h3, 4'hF, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,            64'h0,            1'b1,           1'b0,           1'b1};
        tbl[7]  = '{4'h3, 4'hF, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,            64'h0,            1'b1,           1'b0,           1'b0};
        tbl[8]  = '{4'h0, 4'hF, 1'b1, 4'h3, 4'h3, 4'h3, 4'hF, 64'h33,   64'h0,    64'h1234,         64'h0,            1'b0,           1'b0,           1'b0};
        tbl[9]  = '{4'h1, 4'h2, 1'b1, 4'h3, 4'hF, 4'h3, 4'h3, 64'h44,   64'h55,   64'h5678,         64'h0,            1'b0,           1'b0,           1'b1};
        tbl[10] = '{4'h3, 4'h3, 1'b0, 4'hF, 4'hF, 4'h3, 4'hF, 64'h66,   64'h0,    BYP ? 64'h66 : 64'h55, BYP ? 64'h66 : 64'h55, !BYP, !BYP, 1'b1};
        tbl[11] = '{4'h3, 4'hF, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h66,           64'h0,            1'b0,           1'b0,           1'b1};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].iv, tbl[i].ie, tbl[i].im,
                  tbl[i].de, tbl[i].dm, tbl[i].ve, tbl[i].vm);
            #1;
            chk($sformatf("t%0d_valA", i), valA, tbl[i].xa);
            chk($sformatf("t%0d_valB", i), valB, tbl[i].xb);
            chk($sformatf("t%0d_busyA", i), 64'(busyA), 64'(tbl[i].ba));
            chk($sformatf("t%0d_busyB", i), 64'(busyB), 64'(tbl[i].bb));
            chk($sformatf("t%0d_ready", i), 64'(iss_ready), 64'(tbl[i].rdy));
            cycle();
        end

        // Same-cycle issue and retire on one register keeps its count
        drive(4'hF, 4'h2, 1'b1, 4'h2, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        cycle();
        drive(4'hF, 4'h2, 1'b1, 4'h2, 4'hF, 4'hF, 4'h2, 64'h0, 64'h22);
        #1 chk("p4_ready", 64'(iss_ready), 64'h1);
        cycle();
        idle(4'hF, 4'h2);
        #1 chk("p4_busyB", 64'(busyB), 64'h1);
        chk("p4_valB", valB, 64'h22);
        drive(4'hF, 4'h2, 1'b0, 4'hF, 4'hF, 4'hF, 4'h2, 64'h0, 64'h23);
        cycle();
        idle(4'hF, 4'h2);
        #1 chk("p4_drained", 64'(busyB), 64'h0);

        // RNONE is neither readable nor writable
        drive(4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'hFFFF, 64'h0);
        #1 chk("p5_valA", valA, 64'h0);
        cycle();
        idle(4'hF, 4'h0);
        #1 chk("p5_valA_after", valA, 64'h0);
        chk("p5_busyA", 64'(busyA), 64'h0);
        check_all("p5");

        // Writeback forwarding to a same-cycle read
        drive(4'hF, 4'hF, 1'b1, 4'h5, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        cycle();
        drive(4'h5, 4'hF, 1'b0, 4'hF, 4'hF, 4'h5, 4'hF, 64'h77, 64'h0);
        #1 chk("p6_valA", valA, BYP ? 64'h77 : 64'h0);
        chk("p6_busyA", 64'(busyA), BYP ? 64'h0 : 64'h1);
        cycle();
        idle(4'h5, 4'hF);
        #1 chk("p6_valA_after", valA, 64'h77);
        chk("p6_busyA_after", 64'(busyA), 64'h0);

        // Random traffic against the model, retiring only outstanding writes
        for (int n = 0; n < 400; n++) begin
            de = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if (de != 4'hF && cnt[de] == 0) de = 4'hF;
            dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if (dm != 4'hF && cnt[dm] < ((dm == de) ? 2 : 1)) dm = 4'hF;
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                  ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                  de, dm, {$urandom, $urandom}, {$urandom, $urandom});
            #1 check_all($sformatf("rnd%0d", n));
            cycle();
        end

        // Asynchronous reset mid-run discards data and outstanding issues
        drive(4'hF, 4'hF, 1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        while (!m_ready()) begin
            idle(4'hF, 4'hF);
            for (int r = 0; r < 15; r++) begin
                if (cnt[r] > 0) dstE = 4'(r);
            end
            cycle();
            drive(4'hF, 4'hF, 1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        end
        cycle();
        drive(4'h1, 4'hF, 1'b1, 4'h1, 4'hF, 4'h0, 4'hF, 64'h1234, 64'h0);
        #1 chk("p1_ready_pre", 64'(iss_ready), 64'(m_ready()));
        cycle();
        drive(4'h1, 4'h0, 1'b1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        #1 chk("p1_busy_pre", 64'(busyA), 64'h1);
        chk("p1_rax_pre", valB, 64'h1234);
        rst = 1'b1;
        #1;
        chk_flat("p1_flat", '0);
        chk("p1_busyA", 64'(busyA), 64'h0);
        chk("p1_ready", 64'(iss_ready), 64'h1);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4'h1, 4'h0);
        #1 check_all("p1_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file for the pipelined Y86-64 core.
- N-entry, W-bit register file with two read ports (A, B) and two write ports (E, M).
- Integrated per-register pending-write scoreboard: decode issues destinations, writeback retires them, and busy flags drive the hazard/stall unit.
- Sits between the decode and writeback stages.

Parameters:
- WIDTH, 64, data word width in bits.
- AW, 4, register index width; NREG = 2**AW entries; index all-ones (RNONE) is never stored.
- CNTW, 2, scoreboard counter width; up to 2**CNTW-1 outstanding writes per register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- srcA  in  AW  read index A; RNONE = no read.
- srcB  in  AW  read index B; RNONE = no read.
- valA  out  WIDTH  read data A.
- valB  out  WIDTH  read data B.
- busyA  out  1  srcA has outstanding writes.
- busyB  out  1  srcB has outstanding writes.
- iss_valid  in  1  decode issues an instruction's destinations this cycle.
- iss_dstE  in  AW  issued E destination; RNONE = none.
- iss_dstM  in  AW  issued M destination; RNONE = none.
- iss_ready  out  1  issue accepted (no counter would overflow).
- dstE  in  AW  writeback E index; RNONE = no write.
- dstM  in  AW  writeback M index; RNONE = no write.
- valE  in  WIDTH  writeback E data.
- valM  in  WIDTH  writeback M data.
- regs_flat  out  NREG*WIDTH  debug view; entry i at bits [i*WIDTH +: WIDTH]; RNONE slice reads 0.

Behaviour:
- Reset:
  - Async assert clears every register to 0 and every counter to 0.
  - valA/valB read 0; busyA/busyB = 0; iss_ready = 1.
  - Reset mid-operation discards all outstanding issues.
- Reads:
  - Combinational: valX = regs[srcX].
  - srcX == RNONE gives valX = 0 (no latch; differs from the old block).
- Writes:
  - Rising edge: regs[dstE] <= valE if dstE != RNONE, and regs[dstM] <= valM if dstM != RNONE.
  - If dstE == dstM != RNONE, valM wins (pop %rsp semantics).
- Scoreboard:
  - One counter per register.
  - Increment for each valid issued destination (iss_valid & iss_ready & iss_dstX != RNONE).
  - Decrement for each writeback destination != RNONE.
  - If iss_dstE == iss_dstM the counter increments by 2.
  - If dstE == dstM at writeback the counter decrements by 2.
  - Simultaneous increment and decrement on the same register apply the net delta in one cycle.
  - Decrement of a zero counter is a protocol error: counter stays 0 (assertion in simulation).
- iss_ready:
  - Combinational.
  - Low if any issued destination's counter, after that cycle's retire decrement, would exceed 2**CNTW-1.
  - When iss_ready is low, no counter increments.
- busyX:
  - busyX = (srcX != RNONE) & (counter[srcX] != 0), evaluated on current registered state (no same-cycle retire credit unless bypass is enabled).
- Latency:
  - Write to read: 1 cycle (read in the following cycle).
  - Issue to busy: 1 cycle.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-through forwarding.
  - If srcX matches a same-cycle writeback dstE/dstM, valX returns that incoming data, with M priority.
  - busyX ignores one pending write being retired on that port that cycle (counter - retires == 0 → not busy).
- Undefined: reads see only registered state; busy uses the raw counter.

Decomposition:
- Shared package/defines file:
  - RNONE constant (all-ones of AW).
  - Y86 register index names (RAX=0 … R14=14).
  - WORD width macro reused from the existing defines.
- One natural sub-module: regfile_sb_cnt, a single saturating up/down scoreboard counter with inc1/inc2/dec1/dec2 inputs and an overflow-check output, instantiated NREG-1 times via generate.

Test Plan:
1. Reset mid-run:
   - Stimulus: assert rst after writing rax=0x1234 and issuing rcx.
   - Required: regs_flat all 0, busyA=0 for srcA=1, iss_ready=1 immediately, before any clock edge.
2. Dual-write collision:
   - Stimulus: dstE=dstM=4, valE=0xAA, valM=0xBB, one edge, then srcA=4.
   - Required: valA=0xBB.
3. Scoreboard fill:
   - Stimulus: issue iss_dstE=3 three times, then a fourth.
   - Required: iss_ready=0 on the fourth; busyA=1 for srcA=3; three writebacks dstE=3 → busyA=0 after the third edge.
4. Same-cycle issue and retire:
   - Stimulus: counter[2]=1; issue dstE=2 while writing back dstM=2.
   - Required: counter stays 1, busyB=1 for srcB=2.
5. RNONE handling:
   - Stimulus: srcA=0xF; dstE=0xF with valE=0xFFFF.
   - Required: valA=0, regs_flat unchanged, no counter change.
6. Bypass, REGFILE_BYPASS_EN only:
   - Stimulus: counter[5]=1, dstE=5, valE=0x77, srcA=5 in the same cycle.
   - Required: valA=0x77, busyA=0 combinationally.
   - Without the macro: valA = old value, busyA=1.
